// File: rtl/ariane_axi_id_serializer.sv
// Collapses wide upstream AXI IDs onto one fixed downstream ID by allowing a
// single outstanding write and a single outstanding read, restoring the ID on the way back.
package ariane_soc;
  localparam int unsigned IdWidth      = 4;
  localparam int unsigned IdWidthSlave = 2;
endpackage

package ariane_axi;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  typedef logic [ariane_soc::IdWidth-1:0]      id_t;
  typedef logic [ariane_soc::IdWidthSlave-1:0] id_slv_t;
  typedef logic [AddrWidth-1:0]                addr_t;
  typedef logic [DataWidth-1:0]                data_t;
  typedef logic [StrbWidth-1:0]                strb_t;
  typedef logic [UserWidth-1:0]                user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    id_slv_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
  } aw_chan_slv_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_slv_t    id;
    logic [1:0] resp;
  } b_chan_slv_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_slv_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } ar_chan_slv_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    id_slv_t    id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_slv_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  typedef struct packed {
    aw_chan_slv_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    ar_chan_slv_t ar;
    logic         ar_valid;
    logic         r_ready;
  } req_slv_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    b_chan_slv_t b;
    logic        r_valid;
    r_chan_slv_t r;
  } resp_slv_t;
endpackage

module ariane_axi_id_serializer #(
  parameter logic [ariane_soc::IdWidthSlave-1:0] SlvId = {ariane_soc::IdWidthSlave{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  ariane_axi::req_t      slv_req_i,
  output ariane_axi::resp_t     slv_resp_o,
  output ariane_axi::req_slv_t  mst_req_o,
  input  ariane_axi::resp_slv_t mst_resp_i
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e                       r_w_state, w_w_state_nxt;
  r_state_e                       r_r_state, w_r_state_nxt;
  logic [ariane_soc::IdWidth-1:0] r_wid, r_rid;
  logic                           w_aw_hs, w_w_last_hs, w_b_hs, w_ar_hs, w_r_last_hs;

  // Channel wiring: payloads always routed, valid/ready opened only in the owning phase
  always_comb begin
    mst_req_o            = '0;
    slv_resp_o           = '0;
    mst_req_o.aw.id      = SlvId;
    mst_req_o.aw.addr    = slv_req_i.aw.addr;
    mst_req_o.aw.len     = slv_req_i.aw.len;
    mst_req_o.aw.size    = slv_req_i.aw.size;
    mst_req_o.aw.burst   = slv_req_i.aw.burst;
    mst_req_o.aw.lock    = slv_req_i.aw.lock;
    mst_req_o.aw.cache   = slv_req_i.aw.cache;
    mst_req_o.aw.prot    = slv_req_i.aw.prot;
    mst_req_o.aw.qos     = slv_req_i.aw.qos;
    mst_req_o.aw.region  = slv_req_i.aw.region;
    mst_req_o.aw.atop    = 6'b000000;
    mst_req_o.w          = slv_req_i.w;
    mst_req_o.ar.id      = SlvId;
    mst_req_o.ar.addr    = slv_req_i.ar.addr;
    mst_req_o.ar.len     = slv_req_i.ar.len;
    mst_req_o.ar.size    = slv_req_i.ar.size;
    mst_req_o.ar.burst   = slv_req_i.ar.burst;
    mst_req_o.ar.lock    = slv_req_i.ar.lock;
    mst_req_o.ar.cache   = slv_req_i.ar.cache;
    mst_req_o.ar.prot    = slv_req_i.ar.prot;
    mst_req_o.ar.qos     = slv_req_i.ar.qos;
    mst_req_o.ar.region  = slv_req_i.ar.region;
    slv_resp_o.b.id      = r_wid;
    slv_resp_o.b.resp    = mst_resp_i.b.resp;
    slv_resp_o.r.id      = r_rid;
    slv_resp_o.r.data    = mst_resp_i.r.data;
    slv_resp_o.r.resp    = mst_resp_i.r.resp;
    slv_resp_o.r.last    = mst_resp_i.r.last;
    if (rst_ni) begin
      case (r_w_state)
        W_IDLE: begin
          mst_req_o.aw_valid  = slv_req_i.aw_valid;
          slv_resp_o.aw_ready = mst_resp_i.aw_ready;
        end
        W_DATA: begin
          mst_req_o.w_valid  = slv_req_i.w_valid;
          slv_resp_o.w_ready = mst_resp_i.w_ready;
        end
        W_RESP: begin
          slv_resp_o.b_valid = mst_resp_i.b_valid;
          mst_req_o.b_ready  = slv_req_i.b_ready;
        end
        default: begin
          mst_req_o.aw_valid = 1'b0;
        end
      endcase
      case (r_r_state)
        R_IDLE: begin
          mst_req_o.ar_valid  = slv_req_i.ar_valid;
          slv_resp_o.ar_ready = mst_resp_i.ar_ready;
        end
        R_DATA: begin
          slv_resp_o.r_valid = mst_resp_i.r_valid;
          mst_req_o.r_ready  = slv_req_i.r_ready;
        end
        default: begin
          mst_req_o.ar_valid = 1'b0;
        end
      endcase
    end else begin
      mst_req_o.aw_valid = 1'b0;
      mst_req_o.ar_valid = 1'b0;
    end
  end

  // Handshakes seen on the gated downstream side
  always_comb begin
    w_aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    w_w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
    w_b_hs      = mst_resp_i.b_valid & mst_req_o.b_ready;
    w_ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    w_r_last_hs = mst_resp_i.r_valid & mst_req_o.r_ready & mst_resp_i.r.last;
  end

  // Next-phase selection for both independent paths
  always_comb begin
    w_w_state_nxt = r_w_state;
    w_r_state_nxt = r_r_state;
    case (r_w_state)
      W_IDLE:  if (w_aw_hs) w_w_state_nxt = W_DATA; else w_w_state_nxt = W_IDLE;
      W_DATA:  if (w_w_last_hs) w_w_state_nxt = W_RESP; else w_w_state_nxt = W_DATA;
      W_RESP:  if (w_b_hs) w_w_state_nxt = W_IDLE; else w_w_state_nxt = W_RESP;
      default: w_w_state_nxt = W_IDLE;
    endcase
    case (r_r_state)
      R_IDLE:  if (w_ar_hs) w_r_state_nxt = R_DATA; else w_r_state_nxt = R_IDLE;
      R_DATA:  if (w_r_last_hs) w_r_state_nxt = R_IDLE; else w_r_state_nxt = R_DATA;
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // Phase registers and captured upstream IDs; reset abandons any in-flight burst
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_w_state <= W_IDLE;
      r_r_state <= R_IDLE;
      r_wid     <= {ariane_soc::IdWidth{1'b0}};
      r_rid     <= {ariane_soc::IdWidth{1'b0}};
    end else begin
      r_w_state <= w_w_state_nxt;
      r_r_state <= w_r_state_nxt;
      if (w_aw_hs) r_wid <= slv_req_i.aw.id;
      if (w_ar_hs) r_rid <= slv_req_i.ar.id;
    end
  end

endmodule

// File: tb/tb_ariane_axi_id_serializer.sv
// Directed and randomized checks of the ID serializer against a transaction-level model.
module tb_ariane_axi_id_serializer;
  localparam logic [1:0] SLV_ID = 2'd0;

  logic                  clk_i;
  logic                  rst_ni;
  ariane_axi::req_t      slv_req;
  ariane_axi::resp_t     slv_resp;
  ariane_axi::req_slv_t  mst_req;
  ariane_axi::resp_slv_t mst_resp;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: IDs of accepted-but-unfinished transactions, plus whether write data is done
  logic [3:0] w_ids[$];
  logic [3:0] r_ids[$];
  bit         w_done;

  ariane_axi_id_serializer #(.SlvId(SLV_ID)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit aw_open();
    return rst_ni && w_ids.size() == 0;
  endfunction
  function automatic bit w_open();
    return rst_ni && w_ids.size() == 1 && !w_done;
  endfunction
  function automatic bit b_open();
    return rst_ni && w_ids.size() == 1 && w_done;
  endfunction
  function automatic bit ar_open();
    return rst_ni && r_ids.size() == 0;
  endfunction
  function automatic bit r_open();
    return rst_ni && r_ids.size() == 1;
  endfunction

  task automatic settle();
    @(negedge clk_i);
    chk("aw_valid", 64'(mst_req.aw_valid),  64'(aw_open() && slv_req.aw_valid));
    chk("aw_ready", 64'(slv_resp.aw_ready), 64'(aw_open() && mst_resp.aw_ready));
    chk("w_valid",  64'(mst_req.w_valid),   64'(w_open() && slv_req.w_valid));
    chk("w_ready",  64'(slv_resp.w_ready),  64'(w_open() && mst_resp.w_ready));
    chk("b_valid",  64'(slv_resp.b_valid),  64'(b_open() && mst_resp.b_valid));
    chk("b_ready",  64'(mst_req.b_ready),   64'(b_open() && slv_req.b_ready));
    chk("ar_valid", 64'(mst_req.ar_valid),  64'(ar_open() && slv_req.ar_valid));
    chk("ar_ready", 64'(slv_resp.ar_ready), 64'(ar_open() && mst_resp.ar_ready));
    chk("r_valid",  64'(slv_resp.r_valid),  64'(r_open() && mst_resp.r_valid));
    chk("r_ready",  64'(mst_req.r_ready),   64'(r_open() && slv_req.r_ready));
    if (aw_open() && slv_req.aw_valid) begin
      chk("aw_id",   64'(mst_req.aw.id),   64'(SLV_ID));
      chk("aw_addr", mst_req.aw.addr,      slv_req.aw.addr);
      chk("aw_len",  64'(mst_req.aw.len),  64'(slv_req.aw.len));
      chk("aw_atop", 64'(mst_req.aw.atop), 64'd0);
    end
    if (w_open() && slv_req.w_valid) begin
      chk("w_data", mst_req.w.data,      slv_req.w.data);
      chk("w_last", 64'(mst_req.w.last), 64'(slv_req.w.last));
    end
    if (b_open() && mst_resp.b_valid) begin
      chk("b_id",   64'(slv_resp.b.id),   64'(w_ids[0]));
      chk("b_resp", 64'(slv_resp.b.resp), 64'(mst_resp.b.resp));
    end
    if (ar_open() && slv_req.ar_valid) begin
      chk("ar_id",   64'(mst_req.ar.id),  64'(SLV_ID));
      chk("ar_addr", mst_req.ar.addr,     slv_req.ar.addr);
      chk("ar_len",  64'(mst_req.ar.len), 64'(slv_req.ar.len));
    end
    if (r_open() && mst_resp.r_valid) begin
      chk("r_id",   64'(slv_resp.r.id),   64'(r_ids[0]));
      chk("r_data", slv_resp.r.data,      mst_resp.r.data);
      chk("r_last", 64'(slv_resp.r.last), 64'(mst_resp.r.last));
    end
  endtask

  task automatic tick();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    @(posedge clk_i);
    aw_hs = aw_open() && slv_req.aw_valid && mst_resp.aw_ready;
    w_hs  = w_open() && slv_req.w_valid && mst_resp.w_ready && slv_req.w.last;
    b_hs  = b_open() && mst_resp.b_valid && slv_req.b_ready;
    ar_hs = ar_open() && slv_req.ar_valid && mst_resp.ar_ready;
    r_hs  = r_open() && mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
    if (!rst_ni) begin
      w_ids.delete();
      r_ids.delete();
      w_done = 1'b0;
    end else begin
      if (aw_hs) w_ids.push_back(slv_req.aw.id);
      if (w_hs) w_done = 1'b1;
      if (b_hs) begin
        void'(w_ids.pop_front());
        w_done = 1'b0;
      end
      if (ar_hs) r_ids.push_back(slv_req.ar.id);
      if (r_hs) void'(r_ids.pop_front());
    end
    #1;
  endtask

  task automatic idle();
    slv_req  = '0;
    mst_resp = '0;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  initial begin
    w_done = 1'b0;
    idle();
    rst_ni = 1'b0;
    slv_req.aw_valid = 1'b1;
    mst_resp.b_valid = 1'b1;
    settle();
    chk("rst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
    chk("rst_b_valid",  64'(slv_resp.b_valid), 64'd0);
    tick();
    cycle();
    idle();
    rst_ni = 1'b1;

    // Single write, id 5, two beats
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd5; slv_req.aw.addr = 64'h80; slv_req.aw.len = 8'd1;
    mst_resp.aw_ready = 1'b1;
    settle();
    chk("wr_aw_id0", 64'(mst_req.aw.id), 64'd0);
    tick();
    idle();
    slv_req.w_valid = 1'b1; slv_req.w.data = 64'hA5A5_0000_1111_2222; mst_resp.w_ready = 1'b1;
    cycle();
    slv_req.w.last = 1'b1; slv_req.w.data = 64'h0123_4567_89AB_CDEF;
    cycle();
    idle();
    mst_resp.b_valid = 1'b1; mst_resp.b.id = SLV_ID; mst_resp.b.resp = 2'b00; slv_req.b_ready = 1'b1;
    settle();
    chk("wr_b_id5",  64'(slv_resp.b.id), 64'd5);
    chk("wr_b_okay", 64'(slv_resp.b.resp), 64'd0);
    tick();
    idle();
    slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    settle();
    chk("wr_back_idle", 64'(slv_resp.aw_ready), 64'd1);
    idle();
    tick();

    // Read burst id 3, four beats; AR id 7 must stall until after the last beat
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd3; slv_req.ar.len = 8'd3; mst_resp.ar_ready = 1'b1;
    cycle();
    slv_req.ar.id = 4'd7; slv_req.r_ready = 1'b1; mst_resp.r_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mst_resp.r.data = {$urandom, $urandom};
      mst_resp.r.last = (i == 3);
      settle();
      chk("rd_stall_ar7", 64'(slv_resp.ar_ready), 64'd0);
      chk("rd_beat_id3",  64'(slv_resp.r.id), 64'd3);
      tick();
    end
    mst_resp.r_valid = 1'b0;
    settle();
    chk("rd_ar7_accept", 64'(slv_resp.ar_ready), 64'd1);
    tick();
    idle();
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1; slv_req.r_ready = 1'b1;
    settle();
    chk("rd_id7", 64'(slv_resp.r.id), 64'd7);
    tick();
    idle();

    // Concurrent AW id 1 and AR id 2
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd1; slv_req.ar_valid = 1'b1; slv_req.ar.id = 4'd2;
    mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1;
    settle();
    chk("cc_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
    chk("cc_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
    tick();
    idle();
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1; mst_resp.w_ready = 1'b1;
    mst_resp.r_valid = 1'b1; slv_req.r_ready = 1'b1;
    cycle();
    idle();
    mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1; slv_req.r_ready = 1'b1;
    settle();
    chk("cc_b_id1", 64'(slv_resp.b.id), 64'd1);
    chk("cc_r_id2", 64'(slv_resp.r.id), 64'd2);
    tick();
    idle();

    // Upstream B backpressure for 10 cycles
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd4; mst_resp.aw_ready = 1'b1;
    cycle();
    idle();
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1; mst_resp.w_ready = 1'b1;
    cycle();
    idle();
    mst_resp.b_valid = 1'b1; slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd8; mst_resp.aw_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("bp_b_ready", 64'(mst_req.b_ready), 64'd0);
      chk("bp_b_held",  64'(slv_resp.b_valid), 64'd1);
      chk("bp_no_aw",   64'(slv_resp.aw_ready), 64'd0);
      tick();
    end
    slv_req.aw_valid = 1'b0; slv_req.b_ready = 1'b1;
    cycle();
    idle();

    // Reset in W_DATA after one of four beats, then a fresh write id 9
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd6; slv_req.aw.len = 8'd3; mst_resp.aw_ready = 1'b1;
    cycle();
    idle();
    slv_req.w_valid = 1'b1; mst_resp.w_ready = 1'b1;
    cycle();
    rst_ni = 1'b0;
    tick();
    settle();
    chk("rs_w_valid", 64'(mst_req.w_valid), 64'd0);
    chk("rs_w_ready", 64'(slv_resp.w_ready), 64'd0);
    rst_ni = 1'b1;
    settle();
    chk("rs_idle_w", 64'(mst_req.w_valid), 64'd0);
    tick();
    idle();
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 4'd9; mst_resp.aw_ready = 1'b1;
    cycle();
    idle();
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1; mst_resp.w_ready = 1'b1;
    cycle();
    idle();
    mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
    settle();
    chk("rs_b_id9", 64'(slv_resp.b.id), 64'd9);
    tick();
    idle();

    // Atomic opcode stripped; stray B while idle left alone
    slv_req.aw_valid = 1'b1; slv_req.aw.atop = 6'h20;
    mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
    settle();
    chk("atop_zero",   64'(mst_req.aw.atop), 64'd0);
    chk("stray_b_rdy", 64'(mst_req.b_ready), 64'd0);
    chk("stray_b_vld", 64'(slv_resp.b_valid), 64'd0);
    tick();
    idle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rst_ni             = ($urandom_range(0, 63) != 0);
      slv_req.aw_valid   = 1'($urandom);
      slv_req.aw.id      = 4'($urandom);
      slv_req.aw.addr    = {$urandom, $urandom};
      slv_req.aw.len     = 8'($urandom_range(0, 3));
      slv_req.aw.atop    = 6'($urandom);
      slv_req.w_valid    = 1'($urandom);
      slv_req.w.data     = {$urandom, $urandom};
      slv_req.w.last     = ($urandom_range(0, 2) == 0);
      slv_req.b_ready    = 1'($urandom);
      slv_req.ar_valid   = 1'($urandom);
      slv_req.ar.id      = 4'($urandom);
      slv_req.ar.addr    = {$urandom, $urandom};
      slv_req.ar.len     = 8'($urandom_range(0, 3));
      slv_req.r_ready    = 1'($urandom);
      mst_resp.aw_ready  = 1'($urandom);
      mst_resp.w_ready   = 1'($urandom);
      mst_resp.b_valid   = 1'($urandom);
      mst_resp.b.id      = 2'($urandom);
      mst_resp.b.resp    = 2'($urandom);
      mst_resp.ar_ready  = 1'($urandom);
      mst_resp.r_valid   = 1'($urandom);
      mst_resp.r.id      = 2'($urandom);
      mst_resp.r.data    = {$urandom, $urandom};
      mst_resp.r.resp    = 2'($urandom);
      mst_resp.r.last    = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ariane_axi_id_serializer.md
ARIANE_AXI_ID_SERIALIZER -- requirements
Module: ariane_axi_id_serializer

Interface
REQ-001 SHALL have parameter SlvId, default 0, meaning the fixed ID driven on every master-side AW/AR (width ariane_soc::IdWidthSlave).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port slv_req_i  input  ariane_axi::req_t  upstream requests (full-width ID, user).
REQ-005 SHALL have port slv_resp_o  output  ariane_axi::resp_t  upstream responses.
REQ-006 SHALL have port mst_req_o  output  ariane_axi::req_slv_t  downstream requests (narrow ID, no user).
REQ-007 SHALL have port mst_resp_i  input  ariane_axi::resp_slv_t  downstream responses.

Function
REQ-008 SHALL allow at most one outstanding write and one outstanding read; read and write paths operate independently and concurrently.
REQ-009 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM SHALL have states R_IDLE, R_DATA.
REQ-010 W_IDLE: mst aw_valid = slv aw_valid, slv aw_ready = mst aw_ready; AW fields copied except id = SlvId, user dropped, atop forced to 0.
REQ-011 AW handshake in W_IDLE SHALL latch upstream aw.id into wid_q and move to W_DATA next cycle.
REQ-012 W_DATA: w channel SHALL pass through unchanged (w_valid/w_ready combinationally connected); handshake with w.last=1 -> W_RESP.
REQ-013 W_RESP: slv b_valid = mst b_valid, mst b_ready = slv b_ready, slv b.id = wid_q, b.resp passed; B handshake -> W_IDLE.
REQ-014 Outside W_IDLE: mst aw_valid = 0, slv aw_ready = 0. Outside W_DATA: mst w_valid = 0, slv w_ready = 0. Outside W_RESP: slv b_valid = 0, mst b_ready = 0.
REQ-015 R_IDLE: AR passed as in REQ-010 (id = SlvId, user dropped); AR handshake latches ar.id into rid_q -> R_DATA.
REQ-016 R_DATA: R beats pass through with slv r.id = rid_q, data/resp/last unchanged; handshake with r.last=1 -> R_IDLE.
REQ-017 Outside R_IDLE: mst ar_valid = 0, slv ar_ready = 0. Outside R_DATA: slv r_valid = 0, mst r_ready = 0.
REQ-018 Pass-through latency SHALL be 0 cycles for every channel; no data registered.
REQ-019 Back-to-back: next AW (AR) SHALL be accepted no earlier than the cycle after the completing B (last R) handshake.
REQ-020 Stray downstream B in W_IDLE/W_DATA or R in R_IDLE SHALL be left unacknowledged (ready held 0), never forwarded.
REQ-021 Simultaneous AW and AR handshakes in the same cycle SHALL both be accepted.
REQ-022 Valid SHALL NOT depend on ready in the same direction beyond REQ-010..017 wiring; no combinational path from a ready to its own valid.

Reset
REQ-023 rst_ni=0 at a rising edge SHALL force W_IDLE, R_IDLE, wid_q=0, rid_q=0, including mid-burst; in-flight transaction abandoned.
REQ-024 While rst_ni=0 all valid and ready outputs (mst aw/w/ar_valid, b/r_ready; slv aw/w/ar_ready, b/r_valid) SHALL be 0; data fields don't-care.

Verification
REQ-025 Single write: AW id=5 addr=0x80 len=1, 2 W beats, downstream B id=SlvId resp=OKAY -> mst aw.id=0, upstream B id=5 OKAY, FSM back in W_IDLE.
REQ-026 Read burst: AR id=3 len=3, downstream 4 R beats with last on 4th -> upstream 4 beats id=3, data identical, second AR id=7 stalled (ar_ready=0) until cycle after last beat.
REQ-027 Concurrent: AW id=1 and AR id=2 valid same cycle, both ready -> both accepted; interleaved B/R returned with ids 1 and 2.
REQ-028 Backpressure: upstream b_ready=0 for 10 cycles in W_RESP -> mst b_ready=0 same 10 cycles, B held, new AW not accepted.
REQ-029 Reset in W_DATA after 1 of 4 beats -> next cycle all valids/readys 0, state W_IDLE; fresh AW id=9 completes normally with B id=9.
REQ-030 Atomic/stray: AW with atop=0x20 -> mst atop=0; downstream b_valid=1 while W_IDLE -> mst b_ready=0, upstream b_valid=0.
